// File: rtl/axi_lite_read_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_read_master_if
//   Bundles the core-side request/response handshake and the AXI4-Lite read
//   channels (AR, R) used by axi_lite_read_master.
//
//   Core request : req_valid, req_ready, req_addr, req_size, req_signed
//   Core response: resp_valid, resp_ready, resp_data, resp_err
//   AXI AR       : araddr, arvalid, arready
//   AXI R        : rdata, rresp, rvalid, rready
//
//   Modport master : the read initiator (drives req_ready, resp_*, AR, rready)
//   Modport slave  : everything around it (core and bus fabric)
// -----------------------------------------------------------------------------
interface axi_lite_read_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_err;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        input  req_valid, req_addr, req_size, req_signed, resp_ready,
        input  arready, rdata, rresp, rvalid,
        output req_ready, resp_valid, resp_data, resp_err,
        output araddr, arvalid, rready
    );

    modport slave (
        output req_valid, req_addr, req_size, req_signed, resp_ready,
        output arready, rdata, rresp, rvalid,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  araddr, arvalid, rready
    );
endinterface

// File: rtl/axi_lite_read_master.sv
// -----------------------------------------------------------------------------
// axi_lite_read_master
//   Single-outstanding AXI4-Lite read initiator for the core load/fetch path.
//   Takes one core read request (byte/half/word, signed/unsigned), issues one
//   AR beat, collects the R beat, extracts the addressed lane, extends it to
//   32 bits and returns it with an error code (00 ok, 01 misaligned, 10 bus).
//   Misaligned requests are answered locally without any bus traffic.
//
//   Ports:
//     i_clock  - clock
//     i_reset  - synchronous active-high reset
//     bus      - axi_lite_read_master_if.master (core req/resp + AXI AR/R)
// -----------------------------------------------------------------------------
module axi_lite_read_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    axi_lite_read_master_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [1:0]        resp_err_q;

    // OKAY and EXOKAY are treated alike; only rresp[1] separates success from error.
    logic unused_rresp_lo;
    assign unused_rresp_lo = bus.rresp[0];

    // Reserved size 2'b11 is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] size);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    // Select the addressed lane and extend it; signedness is irrelevant for words.
    function automatic logic [DATA_W-1:0] extract_lane(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        a,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract_lane = sgn ? {{(DATA_W-8){b[7]}}, b}   : {{(DATA_W-8){1'b0}}, b};
            2'b01:   extract_lane = sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = is_misaligned(bus.req_addr[1:0], bus.req_size) ? DONE : ADDR;
            end
            ADDR: if (bus.arready)    state_d = DATA;
            DATA: if (bus.rvalid)     state_d = DONE;
            DONE: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and response capture
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            addr_q      <= '0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    addr_q   <= bus.req_addr;
                    size_q   <= bus.req_size;
                    signed_q <= bus.req_signed;
                    if (is_misaligned(bus.req_addr[1:0], bus.req_size)) begin
                        resp_data_q <= '0;
                        resp_err_q  <= ERR_ALIGN;
                    end
                end
                DATA: if (bus.rvalid) begin
                    if (bus.rresp[1]) begin
                        resp_data_q <= '0;
                        resp_err_q  <= ERR_BUS;
                    end else begin
                        resp_data_q <= extract_lane(bus.rdata, addr_q[1:0], size_q, signed_q);
                        resp_err_q  <= ERR_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes, so an R beat outside DATA is never accepted.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.arvalid    = (state_q == ADDR);
    assign bus.rready     = (state_q == DATA);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.araddr     = addr_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_axi_lite_read_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_read_master
//   Directed bench for axi_lite_read_master: a small cycle-stepped AXI slave
//   and core model inside run_read, with expected values written by hand.
// -----------------------------------------------------------------------------
module tb_axi_lite_read_master;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axi_lite_read_master_if bus ();

    axi_lite_read_master dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete core read against a slave with programmable stalls.
    // Cycle numbering: the request is accepted at the edge ending cycle 0.
    task automatic run_read(
        input  string       tag,
        input  logic [31:0] addr,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic [31:0] rd,
        input  logic [1:0]  rr,
        input  int          ar_wait,
        input  int          r_wait,
        input  int          resp_wait,
        output logic [31:0] data,
        output logic [1:0]  err,
        output int          lat,
        output int          ar_cnt
    );
        int cyc, ar_st, r_st, rs_st;
        bit ar_done, r_done, ar_hs, r_hs, got, fin;
        bit ar_pending, ar_bad, resp_bad, busy_bad;
        ar_st = 0; r_st = 0; rs_st = 0; ar_cnt = 0; lat = -1;
        ar_done = 0; r_done = 0; got = 0; fin = 0;
        ar_pending = 0; ar_bad = 0; resp_bad = 0; busy_bad = 0;
        data = 32'h0; err = 2'b11;

        check({tag, "_req_ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        tick();
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_size   = 2'b11;
        bus.req_signed = ~sgn;
        cyc = 1;

        while (!fin && cyc < 80) begin
            ar_hs = 0; r_hs = 0;
            // AR channel
            bus.arready = 1'b0;
            if (bus.arvalid) begin
                if (bus.araddr !== addr) ar_bad = 1;
                if (ar_st >= ar_wait) begin
                    bus.arready = 1'b1;
                    ar_hs = 1;
                    ar_cnt++;
                end
                ar_st++;
            end else if (ar_pending) begin
                ar_bad = 1;
            end
            ar_pending = bus.arvalid && !ar_hs;
            // R channel
            bus.rvalid = 1'b0;
            bus.rdata  = 32'hA5A5_5A5A;
            bus.rresp  = 2'b11;
            if (ar_done && !r_done) begin
                if (r_st >= r_wait) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = rd;
                    bus.rresp  = rr;
                    if (bus.rready) r_hs = 1;
                end
                r_st++;
            end
            // Core response
            bus.resp_ready = 1'b0;
            if (bus.resp_valid) begin
                if (!got) begin
                    got  = 1;
                    lat  = cyc;
                    data = bus.resp_data;
                    err  = bus.resp_err;
                end else if (bus.resp_data !== data || bus.resp_err !== err) begin
                    resp_bad = 1;
                end
                if (rs_st >= resp_wait) begin
                    bus.resp_ready = 1'b1;
                    fin = 1;
                end
                rs_st++;
            end
            if (bus.req_ready) busy_bad = 1;
            tick();
            cyc++;
            if (ar_hs) ar_done = 1;
            if (r_hs)  r_done  = 1;
        end

        bus.arready    = 1'b0;
        bus.rvalid     = 1'b0;
        bus.resp_ready = 1'b0;
        check({tag, "_completed"},     {31'd0, fin},      32'd1);
        check({tag, "_ar_stable"},     {31'd0, ar_bad},   32'd0);
        check({tag, "_resp_stable"},   {31'd0, resp_bad}, 32'd0);
        check({tag, "_busy_no_ready"}, {31'd0, busy_bad}, 32'd0);
        check({tag, "_ready_after"},   {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  e;
        int          lat, arc;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.resp_ready = 1'b0;
        bus.arready    = 1'b0;
        bus.rdata      = 32'h0;
        bus.rresp      = 2'b00;
        bus.rvalid     = 1'b0;
        tick();
        tick();
        check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rst_arvalid",    {31'd0, bus.arvalid},    32'd0);
        check("rst_rready",     {31'd0, bus.rready},     32'd0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_data",  bus.resp_data,           32'h0);
        check("rst_resp_err",   {30'd0, bus.resp_err},   32'd0);
        check("rst_araddr",     bus.araddr,              32'h0);
        rst = 1'b0;
        tick();

        // Aligned word, zero stalls
        run_read("word", 32'h0200_BFF8, 2'b10, 1'b0, 32'h1234_5678, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("word_data", d, 32'h1234_5678);
        check("word_err",  {30'd0, e}, 32'd0);
        check("word_lat",  lat, 32'd3);
        check("word_ar",   arc, 32'd1);

        // Byte lanes with sign/zero extension
        run_read("b1s", 32'h0200_0001, 2'b00, 1'b1, 32'h80FF_7F00, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("b1s_data", d, 32'h0000_007F);
        run_read("b3s", 32'h0200_0003, 2'b00, 1'b1, 32'h80FF_7F00, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("b3s_data", d, 32'hFFFF_FF80);
        run_read("b3u", 32'h0200_0003, 2'b00, 1'b0, 32'h80FF_7F00, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("b3u_data", d, 32'h0000_0080);
        check("b3u_err",  {30'd0, e}, 32'd0);

        // Upper half lane
        run_read("h2s", 32'h0200_0002, 2'b01, 1'b1, 32'h8001_0000, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("h2s_data", d, 32'hFFFF_8001);
        run_read("h2u", 32'h0200_0002, 2'b01, 1'b0, 32'h8001_0000, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("h2u_data", d, 32'h0000_8001);

        // Misaligned requests never reach the bus
        run_read("h1", 32'h0200_0001, 2'b01, 1'b1, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("h1_err",  {30'd0, e}, 32'd1);
        check("h1_data", d, 32'h0);
        check("h1_lat",  lat, 32'd1);
        check("h1_ar",   arc, 32'd0);
        run_read("w2", 32'h0200_0002, 2'b10, 1'b0, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("w2_err", {30'd0, e}, 32'd1);
        check("w2_ar",  arc, 32'd0);
        run_read("sz3", 32'h0200_0000, 2'b11, 1'b0, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("sz3_err", {30'd0, e}, 32'd1);
        check("sz3_ar",  arc, 32'd0);

        // Backpressure on AR, R and the response: 1 + 5 + 1 + 4 + 1 = cycle 12
        run_read("bp", 32'h1000_0004, 2'b10, 1'b0, 32'hCAFE_F00D, 2'b00, 5, 4, 3, d, e, lat, arc);
        check("bp_data", d, 32'hCAFE_F00D);
        check("bp_lat",  lat, 32'd12);
        check("bp_ar",   arc, 32'd1);

        // Slave error, then a normal read
        run_read("slverr", 32'h0200_0000, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, d, e, lat, arc);
        check("slverr_err",  {30'd0, e}, 32'd2);
        check("slverr_data", d, 32'h0);
        run_read("after_err", 32'h0200_0000, 2'b00, 1'b0, 32'h1122_3344, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("after_err_data", d, 32'h0000_0044);
        check("after_err_err",  {30'd0, e}, 32'd0);

        // Reset while waiting for the R beat, then a stale beat
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_size  = 2'b10;
        tick();
        bus.req_valid = 1'b0;
        check("mid_arvalid", {31'd0, bus.arvalid}, 32'd1);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("mid_rready", {31'd0, bus.rready}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("mid_rst_arvalid",    {31'd0, bus.arvalid},    32'd0);
        check("mid_rst_rready",     {31'd0, bus.rready},     32'd0);
        check("mid_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("mid_rst_resp_data",  bus.resp_data,           32'h0);
        check("mid_rst_resp_err",   {30'd0, bus.resp_err},   32'd0);
        check("mid_rst_araddr",     bus.araddr,              32'h0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h5555_5555;
        bus.rresp  = 2'b00;
        check("stale_rready", {31'd0, bus.rready}, 32'd0);
        tick();
        check("stale_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("stale_rready2",    {31'd0, bus.rready},     32'd0);
        bus.rvalid = 1'b0;
        tick();
        run_read("fresh", 32'h0200_BFFC, 2'b10, 1'b1, 32'h0BAD_F00D, 2'b00, 0, 0, 0, d, e, lat, arc);
        check("fresh_data", d, 32'h0BAD_F00D);
        check("fresh_lat",  lat, 32'd3);
        check("fresh_ar",   arc, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
